// File: rtl/fp_mul_core_if.sv
// Operand/result handshake bundle for fp_mul_core.
// master = operand producer / result consumer, slave = the multiplier core.
interface fp_mul_core_if #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    signoA;
  logic                    signoB;
  logic [EXP_W-1:0]        exponenteA;
  logic [EXP_W-1:0]        exponenteB;
  logic [MANT_W-1:0]       mantissaA;
  logic [MANT_W-1:0]       mantissaB;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+MANT_W-1:0] float_res;

  modport master (
    output in_valid, signoA, signoB, exponenteA, exponenteB, mantissaA, mantissaB, out_ready,
    input  in_ready, out_valid, float_res
  );

  modport slave (
    input  in_valid, signoA, signoB, exponenteA, exponenteB, mantissaA, mantissaB, out_ready,
    output in_ready, out_valid, float_res
  );
endinterface

// File: rtl/fp_mul_core.sv
// Sequential single-precision multiplier: radix-2 shift-add mantissa product, one partial product per clock.
// Build option: define FP_ROUND_NEAREST_EN for round-to-nearest-even, otherwise results truncate toward zero.
module fp_mul_core #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int BIAS   = 127
) (
  input logic          clk,
  input logic          rst,
  fp_mul_core_if.slave bus
);
  localparam int PW = 2 * MANT_W;
  localparam int FW = MANT_W - 1;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(MANT_W);
  localparam int RW = EXP_W + MANT_W;

  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [RW-1:0]        QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [MANT_W-1:0]      mcand;
  logic [MANT_W-1:0]      mplier;
  logic [PW-1:0]          prod;
  logic                   sgn;
  logic signed [EW-1:0]   expAcc;
  logic [RW-1:0]          resReg;
  logic                   inReady;
  logic                   outValid;
  logic [RW-1:0]          floatRes;

  logic                   anyZero;
  logic                   anyInf;
  logic [FW-1:0]          nFrac;
  logic [FW-1:0]          rFrac;
  logic                   carry;
  logic                   g;
  logic                   st;
  logic                   rnd;
  logic signed [EW-1:0]   nExp;
  logic [RW-1:0]          normRes;

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.float_res = floatRes;

  assign anyZero = (bus.exponenteA == '0) || (bus.exponenteB == '0);
  assign anyInf  = (bus.exponenteA == '1) || (bus.exponenteB == '1);

  // Normalise the 2.46 product, round, then clamp to inf / flush to zero.
  always_comb begin
    nExp  = expAcc;
    nFrac = prod[PW-3 -: FW];
    g     = prod[PW-FW-3];
    st    = |prod[PW-FW-4:0];
    if (prod[PW-1]) begin
      nFrac = prod[PW-2 -: FW];
      g     = prod[PW-FW-2];
      st    = |prod[PW-FW-3:0];
      nExp  = expAcc + EW'(1);
    end
`ifdef FP_ROUND_NEAREST_EN
    rnd = g & (st | nFrac[0]);
`else
    rnd = 1'b0;
`endif
    {carry, rFrac} = {1'b0, nFrac} + {{FW{1'b0}}, rnd};
    if (carry) nExp = nExp + EW'(1);
    if (nExp >= EMAX)
      normRes = {sgn, {EXP_W{1'b1}}, {FW{1'b0}}};
    else if (nExp[EW-1] || nExp == '0)
      normRes = {sgn, {(RW-1){1'b0}}};
    else
      normRes = {sgn, nExp[EXP_W-1:0], rFrac};
  end

`ifndef FP_ROUND_NEAREST_EN
  logic unusedRnd;
  assign unusedRnd = g | st;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      sgn      <= 1'b0;
      expAcc   <= '0;
      resReg   <= '0;
      inReady  <= 1'b1;
      outValid <= 1'b0;
      floatRes <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sgn     <= bus.signoA ^ bus.signoB;
          expAcc  <= $signed({2'b00, bus.exponenteA}) + $signed({2'b00, bus.exponenteB}) - EW'(BIAS);
          mcand   <= bus.mantissaA;
          mplier  <= bus.mantissaB;
          prod    <= '0;
          cnt     <= '0;
          inReady <= 1'b0;
          // Specials bypass the multiply; NaN ignores the sign.
          if (anyZero && anyInf) begin
            resReg <= QNAN;
            state  <= DONE;
          end else if (anyZero) begin
            resReg <= {bus.signoA ^ bus.signoB, {(RW-1){1'b0}}};
            state  <= DONE;
          end else if (anyInf) begin
            resReg <= {bus.signoA ^ bus.signoB, {EXP_W{1'b1}}, {FW{1'b0}}};
            state  <= DONE;
          end else begin
            state  <= MULT;
          end
        end
        MULT: begin
          if (mplier[0]) prod <= prod + (PW'(mcand) << cnt);
          mplier <= mplier >> 1;
          if (cnt == CW'(MANT_W - 1)) begin
            cnt   <= '0;
            state <= NORM;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        NORM: begin
          resReg <= normRes;
          state  <= DONE;
        end
        DONE: begin
          if (!outValid) begin
            outValid <= 1'b1;
            floatRes <= resReg;
          end else if (bus.out_ready) begin
            outValid <= 1'b0;
            inReady  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mul_core.sv
// Randomised and directed bench for fp_mul_core against an integer-arithmetic float multiply model.
module tb_fp_mul_core;
  logic clk;
  logic rst;
  int   errCnt = 0;
  int   chkCnt = 0;

  fp_mul_core_if bus ();
  fp_mul_core dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FP_ROUND_NEAREST_EN
  localparam logic [31:0] RND_EXP = 32'h40100001;
`else
  localparam logic [31:0] RND_EXP = 32'h40100000;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exact product of the two significands, then scale by 2^-shift with the chosen rounding.
  function automatic logic [31:0] refMul(input logic sA, input logic [7:0] eA, input logic [23:0] mA,
                                         input logic sB, input logic [7:0] eB, input logic [23:0] mB);
    logic s;
    longint unsigned p, q, r, half;
    int e, sh;
    s = sA ^ sB;
    if ((eA == 0 || eB == 0) && (eA == 8'hFF || eB == 8'hFF)) return 32'h7FC00000;
    if (eA == 0 || eB == 0) return {s, 31'h0};
    if (eA == 8'hFF || eB == 8'hFF) return {s, 8'hFF, 23'h0};
    p = longint'(mA) * longint'(mB);
    e = int'(eA) + int'(eB) - 127;
    if (p >= (64'd1 << 47)) begin sh = 24; e++; end
    else sh = 23;
    q = p >> sh;
    r = p - (q << sh);
    half = 64'd1 << (sh - 1);
`ifdef FP_ROUND_NEAREST_EN
    if (r > half || (r == half && q[0])) q++;
`else
    if (r > half) q = q;
`endif
    if (q >= (64'd1 << 24)) begin q = q >> 1; e++; end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], q[22:0]};
  endfunction

  task automatic runOp(input logic sA, input logic [7:0] eA, input logic [23:0] mA,
                       input logic sB, input logic [7:0] eB, input logic [23:0] mB,
                       input logic [31:0] expRes, input int holdCyc, input string tag);
    int lat, expLat;
    expLat = (eA == 0 || eB == 0 || eA == 8'hFF || eB == 8'hFF) ? 1 : 26;
    chk({tag, "_rdyIdle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid   = 1'b1;
    bus.signoA     = sA;  bus.exponenteA = eA;  bus.mantissaA = mA;
    bus.signoB     = sB;  bus.exponenteB = eB;  bus.mantissaB = mB;
    bus.out_ready  = (holdCyc == 0);
    tick();
    // Garbage operands and a random in_valid while busy must have no effect.
    bus.in_valid   = 1'($urandom);
    bus.signoA     = 1'($urandom);  bus.exponenteA = 8'($urandom);  bus.mantissaA = 24'($urandom);
    bus.signoB     = 1'($urandom);  bus.exponenteB = 8'($urandom);  bus.mantissaB = 24'($urandom);
    chk({tag, "_rdyBusy"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(expLat));
    chk({tag, "_res"}, bus.float_res, expRes);
    for (int i = 0; i < holdCyc; i++) begin
      tick();
      chk({tag, "_holdVld"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_holdRes"}, bus.float_res, expRes);
    end
    bus.out_ready = 1'b1;
    tick();
    chk({tag, "_vldDrop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_rdyBack"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic sA, sB;
    logic [7:0] eA, eB;
    logic [23:0] mA, mB;
    int pulses;
    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.out_ready = 1'b1;
    bus.signoA = 1'b0;  bus.exponenteA = '0;  bus.mantissaA = '0;
    bus.signoB = 1'b0;  bus.exponenteB = '0;  bus.mantissaB = '0;
    #1;
    chk("rstRdy", 32'(bus.in_ready), 32'd1);
    chk("rstVld", 32'(bus.out_valid), 32'd0);
    chk("rstRes", bus.float_res, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    runOp(0, 8'h7F, 24'hC00000, 0, 8'h80, 24'h800000, 32'h40400000, 0, "mul15x2");
    runOp(1, 8'h7F, 24'h800000, 0, 8'h80, 24'hC00000, 32'hC0400000, 5, "negBackP");
    runOp(0, 8'h7F, 24'hC00001, 0, 8'h7F, 24'hC00000, RND_EXP,      0, "round");
    runOp(0, 8'hFE, 24'h800000, 0, 8'hFE, 24'h800000, 32'h7F800000, 0, "ovf");
    runOp(0, 8'h01, 24'h800000, 0, 8'h01, 24'h800000, 32'h00000000, 0, "unf");
    runOp(1, 8'h00, 24'h800000, 0, 8'h7F, 24'h800000, 32'h80000000, 0, "zero");
    runOp(0, 8'h00, 24'h800000, 1, 8'hFF, 24'h800000, 32'h7FC00000, 0, "nan");
    runOp(1, 8'hFF, 24'h800000, 1, 8'h85, 24'hA00000, 32'h7F800000, 2, "inf");
    runOp(0, 8'h7F, 24'hFFFFFF, 0, 8'h7F, 24'hFFFFFF,
          refMul(0, 8'h7F, 24'hFFFFFF, 0, 8'h7F, 24'hFFFFFF), 0, "allOnes");

    // Abort mid-multiply: reset is asynchronous and nothing from the aborted op may leak out.
    bus.in_valid = 1'b1;
    bus.signoA = 0;  bus.exponenteA = 8'h80;  bus.mantissaA = 24'hC00000;
    bus.signoB = 0;  bus.exponenteB = 8'h80;  bus.mantissaB = 24'hC00000;
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk("abortVld", 32'(bus.out_valid), 32'd0);
    chk("abortRdy", 32'(bus.in_ready), 32'd1);
    chk("abortRes", bus.float_res, 32'd0);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.out_valid) pulses++;
    end
    chk("abortNoPulse", 32'(pulses), 32'd0);
    runOp(0, 8'h80, 24'hC00000, 1, 8'h80, 24'hC00000, 32'hC1100000, 0, "afterAbort");

    for (int n = 0; n < 150; n++) begin
      sA = 1'($urandom);  sB = 1'($urandom);
      mA = {1'b1, 23'($urandom)};  mB = {1'b1, 23'($urandom)};
      if ($urandom_range(0, 9) == 0) begin
        eA = 8'($urandom);  eB = 8'($urandom);
      end else begin
        eA = 8'($urandom_range(40, 215));  eB = 8'($urandom_range(40, 215));
      end
      runOp(sA, eA, mA, sB, eB, mB, refMul(sA, eA, mA, sB, eB, mB),
            int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
